// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types for the instruction-RAM boot loader: FSM states, frame magic and error codes.
// Pure declarations; no timing or flow-control behaviour of its own.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HDR   = 2'd1,
    ERR_CSUM  = 2'd2,
    ERR_ABORT = 2'd3
  } err_e;

  localparam logic [15:0] BOOT_MAGIC = 16'hB007;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Word-stream input and instruction-RAM write port of the boot loader.
// No backpressure: the receiver strobes words, the RAM accepts every write pulse.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  modport slave (
    input  word_valid, word_data,
    output ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output word_valid, word_data,
    input  ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Parses header/payload/checksum frames into instruction RAM and gates core execution.
// RAM writes land one cycle after their word strobe; no backpressure, words are never stalled.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  imem_boot_ctrl_if.slave   bus,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [7:0]        word_count
);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              hist_q, hist_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        wc_q, wc_d;
  logic              core_run_q, core_run_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              rise, fall;
  logic [7:0]        hdr_len;
  logic              hdr_ok;
  logic              last_word;

  always_comb begin
    rise        = load_req & ~hist_q;
    fall        = ~load_req & hist_q;
    hdr_len     = bus.word_data[7:0];
    hdr_ok      = (bus.word_data[31:16] == BOOT_MAGIC) && (hdr_len != 8'd0)
                  && (32'(hdr_len) <= MAX_WORDS);
    last_word   = ((wc_q + 8'd1) == len_q);

    state_d     = state_q;
    err_d       = err_q;
    hist_d      = load_req;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    len_d       = len_q;
    wc_d        = wc_q;
    ram_wen_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    // A new request always wins, even over a word strobed in the same cycle.
    if (rise) begin
      state_d = ST_HDR;
      err_d   = ERR_NONE;
      wc_d    = 8'd0;
    end else if (fall && (state_q == ST_HDR || state_q == ST_LOAD || state_q == ST_CSUM)) begin
      state_d = ST_ERR;
      err_d   = ERR_ABORT;
    end else if (bus.word_valid) begin
      unique case (state_q)
        ST_HDR: begin
          if (hdr_ok) begin
            state_d = ST_LOAD;
            len_d   = hdr_len;
            ptr_d   = '0;
            acc_d   = '0;
            wc_d    = 8'd0;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_HDR;
          end
        end
        ST_LOAD: begin
          ram_wen_d   = 1'b1;
          ram_addr_d  = ptr_q;
          ram_wdata_d = bus.word_data;
          acc_d       = acc_q + bus.word_data;
          wc_d        = wc_q + 8'd1;
          // Pointer stops on the last word so it never wraps past MAX_WORDS-1.
          if (last_word) begin
            state_d = ST_CSUM;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
        ST_CSUM: begin
          if (bus.word_data == acc_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end
        default: begin
        end
      endcase
    end

    core_run_d = (state_d == ST_DONE) && !load_req;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      err_q       <= ERR_NONE;
      hist_q      <= 1'b0;
      ptr_q       <= '0;
      acc_q       <= '0;
      len_q       <= 8'd0;
      wc_q        <= 8'd0;
      core_run_q  <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      hist_q      <= hist_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      wc_q        <= wc_d;
      core_run_q  <= core_run_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign core_run      = core_run_q;
  assign busy          = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign word_count    = wc_q;

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Sequences loading of the instruction RAM from the serial instruction receiver and gates execution of the single-cycle core. It parses a framed word stream (header, payload, checksum) and writes the payload words to consecutive instruction-RAM word addresses. It releases the core (I_ready) only after a verified load once the host drops its load request. It sits between the serial receiver, the instruction RAM write port and the core's I_ready input.

Parameters:
ADDR_W, 7, instruction-RAM word-address width
DATA_W, 32, word width
MAX_WORDS, 128, largest legal payload length (must be <= 2**ADDR_W)

Ports:
clk  in  1  system clock; all state changes on posedge clk
rst  in  1  reset, synchronous, active-low
load_req  in  1  host load request level (IWEN pin)
word_valid  in  1  one-cycle strobe: word_data holds a complete received word
word_data  in  DATA_W  received word
ram_wen  out  1  instruction-RAM write enable, one-cycle pulse
ram_addr  out  ADDR_W  instruction-RAM word address; valid when ram_wen=1
ram_wdata  out  DATA_W  instruction-RAM write data
core_run  out  1  drives core I_ready; 1 = core executes
busy  out  1  1 in HDR, LOAD, CSUM
done  out  1  1 in DONE
err  out  2  0 none, 1 bad header, 2 checksum mismatch, 3 aborted
word_count  out  8  payload words written in current/last load

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; internal load_req history register = 0; write pointer, checksum accumulator and length register = 0.
- Edge detect: the load_req history register is sampled every cycle. rise = load_req & ~hist. fall = ~load_req & hist.
- Frame format:
  - Header word: [31:16] = 16'hB007 (magic), [15:8] ignored, [7:0] = N.
  - Then N payload words.
  - Then one checksum word = sum of the N payload words, modulo 2^32.
- States:
  - IDLE: word_valid ignored. rise -> HDR.
  - HDR: on word_valid:
    - magic correct and 1 <= N <= MAX_WORDS -> LOAD; latch N; clear pointer, accumulator and word_count.
    - otherwise -> ERR with err=1.
  - LOAD: on word_valid:
    - Next cycle: ram_wen=1, ram_addr=pointer, ram_wdata=word_data (1-cycle registered latency).
    - pointer, word_count and accumulator (+word_data) update.
    - After the N-th word -> CSUM.
  - CSUM: on word_valid, compare word_data with the accumulator. Equal -> DONE. Unequal -> ERR with err=2.
  - DONE: word_valid ignored; no further RAM writes. core_run = 1 in the cycle after load_req is sampled low; 0 while load_req is high.
  - ERR: core_run=0; err holds its code; word_valid ignored.
- Priority in every state: rise takes precedence over word_valid in the same cycle.
  - Next state is HDR; err, done and word_count clear.
  - core_run drops to 0 on the next edge.
  - A rise in HDR/LOAD/CSUM restarts the frame.
- Abort: fall while in HDR, LOAD or CSUM -> ERR with err=3. Words already written stay in RAM; core stays held.
- fall in DONE: enables core_run as above. fall in IDLE/ERR: no effect.
- word_valid while load_req=0 in IDLE/DONE/ERR: ignored, no write.
- Pointer never wraps: the N limit guarantees pointer <= MAX_WORDS-1. Accumulator wraps mod 2^32. word_count saturates at N.
- core_run is registered and is 1 only in DONE with load_req low. It is 0 in every other state and for the whole of reset.
- rst=0 mid-load: immediate return to IDLE, outputs 0. An in-flight ram_wen pulse is suppressed.

Decomposition:
- Shared package boot_pkg:
  - state enum (IDLE, HDR, LOAD, CSUM, DONE, ERR)
  - BOOT_MAGIC = 16'hB007
  - err codes ERR_NONE, ERR_HDR, ERR_CSUM, ERR_ABORT
- No sub-module: edge detection and the checksum accumulator are inline. A single module of about 150-250 lines.

Test Plan:
- Good load: rise; header 32'hB007_0003; words 32'h11, 32'h22, 32'h33; checksum 32'h66; drop load_req.
  - Expect ram_wen pulses at addr 0,1,2 with the matching data, each 1 cycle after its word_valid.
  - Expect done=1, word_count=3, then core_run=1 one cycle after load_req is sampled low.
- Bad magic: header 32'hDEAD_0002.
  - Expect err=1, no ram_wen, core_run=0.
  - A later correct frame after a new rise succeeds.
- N limits: N=0 -> err=1. N=128 with all words 32'hFFFF_FFFF and checksum 32'hFFFF_FF80 -> done=1, last write at addr 127.
- Checksum wrap/mismatch:
  - Words 32'hFFFF_FFFF, 32'h2 with checksum 32'h1 -> done.
  - Same words with checksum 32'h2 -> err=2, core_run=0.
- Abort and restart:
  - Drop load_req after 1 of 3 payload words -> err=3.
  - Rise in the same cycle as a word_valid -> state HDR, that word not written, err cleared.
- Reset mid-load: rst=0 during LOAD -> next cycle all outputs 0, state IDLE, no further ram_wen.
